// File: rtl/tis_node_pkg.sv
// ============================================================================
// Module      : tis_node_pkg
// Description : Shared types and field positions for the TIS-100 style node.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tis_node_pkg;

    localparam int DATA_W  = 8;
    localparam int INSTR_W = 18;

    // Instruction fields, bit 0 is the MSB of the word
    localparam int OPC_HI = 0;
    localparam int OPC_LO = 3;
    localparam int SRC_HI = 4;
    localparam int SRC_LO = 6;
    localparam int DST_HI = 7;
    localparam int DST_LO = 9;
    localparam int IMM_HI = 10;
    localparam int IMM_LO = 17;

    typedef enum logic [3:0] {
        OP_MOV = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_NEG = 4'h3,
        OP_SWP = 4'h4,
        OP_SAV = 4'h5,
        OP_JMP = 4'h6,
        OP_JEZ = 4'h7,
        OP_JNZ = 4'h8,
        OP_JGZ = 4'h9,
        OP_JLZ = 4'hA,
        OP_NOP = 4'hB
    } opcode_e;

    typedef enum logic [2:0] {
        SRC_IN0 = 3'd0,
        SRC_IN1 = 3'd1,
        SRC_IN2 = 3'd2,
        SRC_IN3 = 3'd3,
        SRC_ACC = 3'd4,
        SRC_NIL = 3'd5,
        SRC_IMM = 3'd6
    } src_e;

    typedef enum logic [2:0] {
        DST_OUT0 = 3'd0,
        DST_OUT1 = 3'd1,
        DST_OUT2 = 3'd2,
        DST_OUT3 = 3'd3,
        DST_ACC  = 3'd4,
        DST_NIL  = 3'd5
    } dst_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_NEG = 2'd2
    } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/tis_node_alu.sv
// ============================================================================
// Module      : tis_node_alu
// Description : Combinational ADD/SUB/NEG on the 8-bit accumulator.
//               Saturating arithmetic when TIS_NODE_SAT_EN is defined,
//               modulo-256 wrap otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tis_node_alu
    import tis_node_pkg::*;
(
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result
);

`ifdef TIS_NODE_SAT_EN
    localparam logic [DATA_W-1:0] c_SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] w_full;

    always_comb begin
        case (op)
            ALU_ADD: w_full = {acc[DATA_W-1], acc} + {operand[DATA_W-1], operand};
            ALU_SUB: w_full = {acc[DATA_W-1], acc} - {operand[DATA_W-1], operand};
            default: w_full = {(DATA_W+1){1'b0}} - {acc[DATA_W-1], acc};
        endcase
        // Sign-extended top two bits disagree only on signed overflow
        if (w_full[DATA_W] != w_full[DATA_W-1]) begin
            result = w_full[DATA_W] ? c_SAT_MIN : c_SAT_MAX;
        end else begin
            result = w_full[DATA_W-1:0];
        end
    end
`else
    always_comb begin
        case (op)
            ALU_ADD: result = acc + operand;
            ALU_SUB: result = acc - operand;
            default: result = {DATA_W{1'b0}} - acc;
        endcase
    end
`endif

endmodule

`default_nettype wire

// File: rtl/tis_node_exec.sv
// ============================================================================
// Module      : tis_node_exec
// Description : Single TIS-100 style execution node, one instruction per
//               clock. Optional macro TIS_NODE_SAT_EN selects saturating
//               ADD/SUB/NEG.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tis_node_exec
    import tis_node_pkg::*;
#(
    parameter int          PROG_LEN = 16,
    parameter logic [7:0]  ACC_RST  = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:7]  in0,
    input  logic [0:7]  in1,
    input  logic [0:7]  in2,
    input  logic [0:7]  in3,
    output logic [0:7]  out0,
    output logic [0:7]  out1,
    output logic [0:7]  out2,
    output logic [0:7]  out3,
    output logic [0:3]  out_wr,
    input  logic [0:17] instr,
    output logic [0:7]  addr_instr,
    output logic [0:7]  acc
);

    localparam logic [8:0] c_PROG_LEN = 9'(PROG_LEN);
    localparam logic [7:0] c_PC_LAST  = 8'(PROG_LEN - 1);

    logic [7:0]        r_pc_q,  w_pc_d;
    logic [DATA_W-1:0] r_acc_q, w_acc_d;
    logic [DATA_W-1:0] r_bak_q, w_bak_d;
    logic [DATA_W-1:0] r_out_q [4];
    logic [DATA_W-1:0] w_out_d [4];
    logic [0:3]        r_wr_q,  w_wr_d;

    logic [3:0]        w_opcode;
    logic [2:0]        w_src;
    logic [2:0]        w_dst;
    logic [7:0]        w_imm;
    logic [DATA_W-1:0] w_operand;
    logic [DATA_W-1:0] w_alu_res;
    alu_op_e           w_alu_op;
    logic              w_take;

    always_comb begin
        w_opcode = instr[OPC_HI:OPC_LO];
        w_src    = instr[SRC_HI:SRC_LO];
        w_dst    = instr[DST_HI:DST_LO];
        w_imm    = instr[IMM_HI:IMM_LO];

        case (w_src)
            SRC_IN0: w_operand = in0;
            SRC_IN1: w_operand = in1;
            SRC_IN2: w_operand = in2;
            SRC_IN3: w_operand = in3;
            SRC_ACC: w_operand = r_acc_q;
            SRC_IMM: w_operand = w_imm;
            default: w_operand = '0;
        endcase

        case (w_opcode)
            OP_SUB:  w_alu_op = ALU_SUB;
            OP_NEG:  w_alu_op = ALU_NEG;
            default: w_alu_op = ALU_ADD;
        endcase
    end

    tis_node_alu u_alu (
        .acc     (r_acc_q),
        .operand (w_operand),
        .op      (w_alu_op),
        .result  (w_alu_res)
    );

    always_comb begin
        w_acc_d = r_acc_q;
        w_bak_d = r_bak_q;
        w_out_d = r_out_q;
        w_wr_d  = '0;
        w_take  = 1'b0;

        case (w_opcode)
            OP_MOV: begin
                if (!w_dst[2]) begin
                    w_out_d[w_dst[1:0]] = w_operand;
                    w_wr_d[w_dst[1:0]]  = 1'b1;
                end else if (w_dst == DST_ACC) begin
                    w_acc_d = w_operand;
                end
            end
            OP_ADD, OP_SUB, OP_NEG: w_acc_d = w_alu_res;
            OP_SWP: begin
                w_acc_d = r_bak_q;
                w_bak_d = r_acc_q;
            end
            OP_SAV: w_bak_d = r_acc_q;
            OP_JMP: w_take  = 1'b1;
            OP_JEZ: w_take  = (r_acc_q == '0);
            OP_JNZ: w_take  = (r_acc_q != '0);
            OP_JGZ: w_take  = !r_acc_q[DATA_W-1] && (r_acc_q != '0);
            OP_JLZ: w_take  = r_acc_q[DATA_W-1];
            default: ;
        endcase

        // Out-of-range jump targets restart the program
        if (w_take) begin
            w_pc_d = ({1'b0, w_imm} >= c_PROG_LEN) ? 8'd0 : w_imm;
        end else begin
            w_pc_d = (r_pc_q == c_PC_LAST) ? 8'd0 : r_pc_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc_q  <= '0;
            r_acc_q <= ACC_RST;
            r_bak_q <= ACC_RST;
            r_out_q <= '{default: '0};
            r_wr_q  <= '0;
        end else begin
            r_pc_q  <= w_pc_d;
            r_acc_q <= w_acc_d;
            r_bak_q <= w_bak_d;
            r_out_q <= w_out_d;
            r_wr_q  <= w_wr_d;
        end
    end

    assign out0       = r_out_q[0];
    assign out1       = r_out_q[1];
    assign out2       = r_out_q[2];
    assign out3       = r_out_q[3];
    assign out_wr     = r_wr_q;
    assign addr_instr = r_pc_q;
    assign acc        = r_acc_q;

endmodule

`default_nettype wire

// File: tb/tb_tis_node_exec.sv
// ============================================================================
// Module      : tb_tis_node_exec
// Description : Self-checking bench for tis_node_exec: directed vector table,
//               src/dst sweep, reset abort and randomized reference checking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tis_node_exec;

    localparam int         PROG_LEN = 16;
    localparam logic [7:0] ACC_RST  = 8'h5A;
`ifdef TIS_NODE_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:7]  in_p  [4];
    logic [0:7]  out_p [4];
    logic [0:3]  out_wr;
    logic [0:17] instr;
    logic [0:7]  addr_instr;
    logic [0:7]  acc_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tis_node_exec #(.PROG_LEN(PROG_LEN), .ACC_RST(ACC_RST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0        (in_p[0]),
        .in1        (in_p[1]),
        .in2        (in_p[2]),
        .in3        (in_p[3]),
        .out0       (out_p[0]),
        .out1       (out_p[1]),
        .out2       (out_p[2]),
        .out3       (out_p[3]),
        .out_wr     (out_wr),
        .instr      (instr),
        .addr_instr (addr_instr),
        .acc        (acc_o)
    );

    // Reference state, kept as plain values
    logic [7:0] m_pc, m_acc, m_bak;
    logic [7:0] m_out [4];
    logic [0:3] m_wr;

    function automatic logic [17:0] enc(input logic [3:0] op, input logic [2:0] s,
                                        input logic [2:0] d, input logic [7:0] imm);
        return {op, s, d, imm};
    endfunction

    function automatic logic [7:0] fit(input int r);
        int c;
        c = r;
        if (SAT_BUILD) begin
            if (c > 127)  c = 127;
            if (c < -128) c = -128;
        end
        return c[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [17:0] ins, input bit rst_lo);
        int op, src, dst, a, tgt;
        logic [7:0] val, tmp;
        bit take;
        if (rst_lo) begin
            m_pc = 0; m_acc = ACC_RST; m_bak = ACC_RST; m_wr = '0;
            for (int k = 0; k < 4; k++) m_out[k] = 8'h00;
            return;
        end
        op  = int'(ins[17:14]);
        src = int'(ins[13:11]);
        dst = int'(ins[10:8]);
        tgt = int'(ins[7:0]);
        case (src)
            0, 1, 2, 3: val = in_p[src];
            4:          val = m_acc;
            6:          val = ins[7:0];
            default:    val = 8'h00;
        endcase
        a    = $signed(m_acc);
        take = 1'b0;
        m_wr = '0;
        case (op)
            0: begin
                if (dst < 4) begin
                    m_out[dst] = val;
                    m_wr[dst]  = 1'b1;
                end else if (dst == 4) begin
                    m_acc = val;
                end
            end
            1: m_acc = fit(a + $signed(val));
            2: m_acc = fit(a - $signed(val));
            3: m_acc = fit(-a);
            4: begin tmp = m_acc; m_acc = m_bak; m_bak = tmp; end
            5: m_bak = m_acc;
            6: take = 1'b1;
            7: take = (a == 0);
            8: take = (a != 0);
            9: take = (a > 0);
            10: take = (a < 0);
            default: ;
        endcase
        if (take) m_pc = (tgt >= PROG_LEN) ? 8'd0 : 8'(tgt);
        else      m_pc = 8'((int'(m_pc) + 1) % PROG_LEN);
    endtask

    task automatic cycle(input logic [17:0] ins, input bit rst_lo);
        @(negedge clk);
        instr = ins;
        rst_n = !rst_lo;
        @(posedge clk);
        #1;
        model_step(ins, rst_lo);
        chk("model_pc",  32'(addr_instr), 32'(m_pc));
        chk("model_acc", 32'(acc_o),      32'(m_acc));
        chk("model_wr",  32'(out_wr),     32'(m_wr));
        for (int k = 0; k < 4; k++) chk("model_out", 32'(out_p[k]), 32'(m_out[k]));
    endtask

    typedef struct {
        logic [17:0] ins;
        logic [31:0] inp;
        logic [7:0]  acc;
        logic [7:0]  pc;
        logic [3:0]  wr;
        logic [31:0] outs;
    } vec_t;

    vec_t tbl [27];

    initial begin
        logic [17:0] nop;
        logic [31:0] o1, o2, o3;
        nop   = enc(4'hB, 3'd7, 3'd5, 8'h00);
        o1    = 32'h00A5_0000;
        o2    = 32'h00A5_003C;
        o3    = 32'hFFA5_003C;
        tbl[0]  = '{enc(4'h0, 3'd2, 3'd1, 8'h00), 32'h0000_A500, 8'h5A, 8'd1,  4'b0100, o1};
        tbl[1]  = '{nop,                          32'h0,         8'h5A, 8'd2,  4'b0000, o1};
        tbl[2]  = '{enc(4'h0, 3'd6, 3'd4, 8'h7F), 32'h0,         8'h7F, 8'd3,  4'b0000, o1};
        tbl[3]  = '{enc(4'h1, 3'd6, 3'd5, 8'h01), 32'h0, SAT_BUILD ? 8'h7F : 8'h80, 8'd4, 4'b0, o1};
        tbl[4]  = '{enc(4'h3, 3'd5, 3'd5, 8'h00), 32'h0, SAT_BUILD ? 8'h81 : 8'h80, 8'd5, 4'b0, o1};
        tbl[5]  = '{enc(4'h0, 3'd6, 3'd4, 8'h05), 32'h0,         8'h05, 8'd6,  4'b0000, o1};
        tbl[6]  = '{enc(4'h5, 3'd5, 3'd5, 8'h00), 32'h0,         8'h05, 8'd7,  4'b0000, o1};
        tbl[7]  = '{enc(4'h0, 3'd6, 3'd4, 8'h00), 32'h0,         8'h00, 8'd8,  4'b0000, o1};
        tbl[8]  = '{enc(4'h4, 3'd5, 3'd5, 8'h00), 32'h0,         8'h05, 8'd9,  4'b0000, o1};
        tbl[9]  = '{enc(4'h4, 3'd5, 3'd5, 8'h00), 32'h0,         8'h00, 8'd10, 4'b0000, o1};
        tbl[10] = '{enc(4'h7, 3'd5, 3'd5, 8'h09), 32'h0,         8'h00, 8'd9,  4'b0000, o1};
        tbl[11] = '{enc(4'h0, 3'd6, 3'd4, 8'h03), 32'h0,         8'h03, 8'd10, 4'b0000, o1};
        tbl[12] = '{enc(4'h7, 3'd5, 3'd5, 8'h09), 32'h0,         8'h03, 8'd11, 4'b0000, o1};
        tbl[13] = '{enc(4'h6, 3'd5, 3'd5, 8'h20), 32'h0,         8'h03, 8'd0,  4'b0000, o1};
        tbl[14] = '{enc(4'h0, 3'd0, 3'd3, 8'h00), 32'h3C00_0000, 8'h03, 8'd1,  4'b0001, o2};
        tbl[15] = '{enc(4'h6, 3'd5, 3'd5, 8'h0E), 32'h0,         8'h03, 8'd14, 4'b0000, o2};
        tbl[16] = '{nop,                          32'h0,         8'h03, 8'd15, 4'b0000, o2};
        tbl[17] = '{nop,                          32'h0,         8'h03, 8'd0,  4'b0000, o2};
        tbl[18] = '{enc(4'h9, 3'd5, 3'd5, 8'h05), 32'h0,         8'h03, 8'd5,  4'b0000, o2};
        tbl[19] = '{enc(4'hA, 3'd5, 3'd5, 8'h07), 32'h0,         8'h03, 8'd6,  4'b0000, o2};
        tbl[20] = '{enc(4'h8, 3'd5, 3'd5, 8'h0A), 32'h0,         8'h03, 8'd10, 4'b0000, o2};
        tbl[21] = '{enc(4'h2, 3'd6, 3'd5, 8'h04), 32'h0,         8'hFF, 8'd11, 4'b0000, o2};
        tbl[22] = '{enc(4'hA, 3'd5, 3'd5, 8'h03), 32'h0,         8'hFF, 8'd3,  4'b0000, o2};
        tbl[23] = '{enc(4'h0, 3'd4, 3'd4, 8'h00), 32'h0,         8'hFF, 8'd4,  4'b0000, o2};
        tbl[24] = '{enc(4'h0, 3'd4, 3'd0, 8'h00), 32'h0,         8'hFF, 8'd5,  4'b1000, o3};
        tbl[25] = '{enc(4'h1, 3'd1, 3'd5, 8'h00), 32'h0081_0000, 8'h80, 8'd6,  4'b0000, o3};
        tbl[26] = '{enc(4'h1, 3'd6, 3'd5, 8'hFF), 32'h0, SAT_BUILD ? 8'h80 : 8'h7F, 8'd7, 4'b0, o3};

        rst_n = 1'b0;
        instr = '0;
        for (int k = 0; k < 4; k++) in_p[k] = 8'h00;

        cycle(nop, 1'b1);
        cycle(nop, 1'b1);
        chk("reset_acc", 32'(acc_o), 32'(ACC_RST));
        chk("reset_pc",  32'(addr_instr), 32'd0);

        for (int i = 0; i < 27; i++) begin
            in_p[0] = tbl[i].inp[31:24];
            in_p[1] = tbl[i].inp[23:16];
            in_p[2] = tbl[i].inp[15:8];
            in_p[3] = tbl[i].inp[7:0];
            cycle(tbl[i].ins, 1'b0);
            chk($sformatf("vec%0d_acc", i), 32'(acc_o),      32'(tbl[i].acc));
            chk($sformatf("vec%0d_pc", i),  32'(addr_instr), 32'(tbl[i].pc));
            chk($sformatf("vec%0d_wr", i),  32'(out_wr),     32'(tbl[i].wr));
            chk($sformatf("vec%0d_outs", i), {out_p[0], out_p[1], out_p[2], out_p[3]}, tbl[i].outs);
        end

        // All input-port to output-port MOV pairs
        in_p[0] = 8'h0F; in_p[1] = 8'h1F; in_p[2] = 8'h2F; in_p[3] = 8'h3F;
        for (int s = 0; s < 4; s++) begin
            for (int d = 0; d < 4; d++) begin
                cycle(enc(4'h0, 3'(s), 3'(d), 8'h00), 1'b0);
                chk("sweep_out", 32'(out_p[d]), 32'(8'h0F + 8'(16 * s)));
                chk("sweep_wr",  32'(out_wr),   32'(4'b1000 >> d));
            end
        end

        // Reset asserted on the cycle of an out3 MOV
        cycle(enc(4'h0, 3'd0, 3'd3, 8'h00), 1'b1);
        chk("rstmid_out3", 32'(out_p[3]), 32'd0);
        chk("rstmid_wr",   32'(out_wr), 32'd0);
        chk("rstmid_pc",   32'(addr_instr), 32'd0);
        chk("rstmid_acc",  32'(acc_o), 32'(ACC_RST));

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) in_p[k] = 8'($urandom);
            cycle(18'($urandom), ($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
